// File: rtl/eth_tx_arb_if.sv
// Two source byte streams plus the transmit-block write port driven by eth_tx_arb.
interface eth_tx_arb_if;
  logic [7:0] S0_Byte;
  logic       S0_Valid;
  logic       S0_Last;
  logic       S0_Ready;
  logic [7:0] S1_Byte;
  logic       S1_Valid;
  logic       S1_Last;
  logic       S1_Ready;
  logic [9:0] Eth_Byte;
  logic       Eth_Byte_Valid;

  modport master (
    output S0_Byte, S0_Valid, S0_Last, S1_Byte, S1_Valid, S1_Last,
    input  S0_Ready, S1_Ready, Eth_Byte, Eth_Byte_Valid
  );

  modport slave (
    input  S0_Byte, S0_Valid, S0_Last, S1_Byte, S1_Valid, S1_Last,
    output S0_Ready, S1_Ready, Eth_Byte, Eth_Byte_Valid
  );
endinterface

// File: rtl/eth_tx_arb.sv
// Round-robin whole-frame arbiter/pacer for the RMII transmit byte port; 2-cycle Valid-to-output latency.
// Sources are held off (Ready low) outside a granted frame and while the line drains the previous one.
module eth_tx_arb #(
  parameter int pBYTE_CYCLES    = 4,
  parameter int pOVERHEAD_BYTES = 38,
  parameter int pMIN_PAYLOAD    = 46,
  parameter int pMAX_PAYLOAD    = 1500
) (
  input  logic         Clk,
  input  logic         Rst_n,
  eth_tx_arb_if.slave  bus,
  output logic [1:0]   Grant,
  output logic         Busy,
  output logic         Underrun_Err,
  output logic         Trunc_Err
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] dat;
  } ethWord_t;

  state_t      state;
  logic        rrPtr;
  logic [10:0] len;
  logic [15:0] gapCnt;
  ethWord_t    ethWord;

  logic        grValid;
  logic        grLast;
  logic [7:0]  grByte;
  logic [10:0] lenNext;
  logic        atMax;
  logic [15:0] gapLoad;

  // Line time of a frame with n payload bytes, minus the n cycles already spent writing it.
  function automatic logic [15:0] lineCycles(input logic [10:0] n);
    logic [15:0] n16;
    logic [15:0] padded;
    n16    = {5'd0, n};
    padded = (n16 < 16'(pMIN_PAYLOAD)) ? 16'(pMIN_PAYLOAD) : n16;
    return (padded + 16'(pOVERHEAD_BYTES)) * 16'(pBYTE_CYCLES) - n16;
  endfunction

  always_comb begin
    grValid = Grant[1] ? bus.S1_Valid : bus.S0_Valid;
    grLast  = Grant[1] ? bus.S1_Last  : bus.S0_Last;
    grByte  = Grant[1] ? bus.S1_Byte  : bus.S0_Byte;
    lenNext = len + 11'd1;
    atMax   = (lenNext == 11'(pMAX_PAYLOAD));
    gapLoad = lineCycles((state == XFER) ? lenNext : len);
  end

  assign bus.S0_Ready   = Grant[0] & ((state == XFER) | (state == DRAIN));
  assign bus.S1_Ready   = Grant[1] & ((state == XFER) | (state == DRAIN));
  assign bus.Eth_Byte   = ethWord;
  assign Busy           = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state              <= IDLE;
      Grant              <= 2'b00;
      rrPtr              <= 1'b0;
      len                <= '0;
      gapCnt             <= '0;
      ethWord            <= '0;
      bus.Eth_Byte_Valid <= 1'b0;
      Underrun_Err       <= 1'b0;
      Trunc_Err          <= 1'b0;
    end else begin
      bus.Eth_Byte_Valid <= 1'b0;
      Underrun_Err       <= 1'b0;
      Trunc_Err          <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.S0_Valid | bus.S1_Valid) begin
            state <= XFER;
            len   <= '0;
            if (bus.S0_Valid & bus.S1_Valid) Grant <= rrPtr ? 2'b10 : 2'b01;
            else                             Grant <= bus.S1_Valid ? 2'b10 : 2'b01;
          end
        end
        XFER: begin
          len                <= lenNext;
          bus.Eth_Byte_Valid <= 1'b1;
          if (grValid) begin
            ethWord <= '{sop: (len == '0), eop: (grLast | atMax), dat: grByte};
            if (grLast) begin
              state  <= GAP;
              gapCnt <= gapLoad;
              Grant  <= 2'b00;
              rrPtr  <= ~rrPtr;
            end else if (atMax) begin
              Trunc_Err <= 1'b1;
              state     <= DRAIN;
            end
          end else begin
            // A stall mid-frame would break the FIFO's back-to-back rule: abort the frame here.
            ethWord      <= '{sop: (len == '0), eop: 1'b1, dat: 8'h00};
            Underrun_Err <= 1'b1;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (grValid & grLast) begin
            state  <= GAP;
            gapCnt <= gapLoad;
            Grant  <= 2'b00;
            rrPtr  <= ~rrPtr;
          end
        end
        GAP: begin
          if (gapCnt == '0) state  <= IDLE;
          else              gapCnt <= gapCnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: default instance plus a pMAX_PAYLOAD=8 instance for truncation.
module tb_eth_tx_arb;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  eth_tx_arb_if ifA();
  eth_tx_arb_if ifB();
  logic [1:0] grA, grB;
  logic bzA, bzB, urA, urB, trA, trB;

  eth_tx_arb dutA (.Clk(Clk), .Rst_n(Rst_n), .bus(ifA), .Grant(grA), .Busy(bzA),
                   .Underrun_Err(urA), .Trunc_Err(trA));
  eth_tx_arb #(.pMAX_PAYLOAD(8)) dutB (.Clk(Clk), .Rst_n(Rst_n), .bus(ifB), .Grant(grB), .Busy(bzB),
                   .Underrun_Err(urB), .Trunc_Err(trB));

  int nChecks = 0;
  int nFails  = 0;

  logic       sel;
  logic [8:0] q0[$], q1[$];
  int         i0, i1, stallIdx1, stallLeft1;
  logic [9:0] outQ[$], expQ[$];
  int         sopTick[$], eopTick[$];
  logic [1:0] grantLog[$];
  logic [1:0] prevGrant, sGr;
  int         urCnt, trCnt, cyc, validTick, busyFall, accTick;
  bit         prevBusy, lastBusy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic sop, input logic eop, input logic [7:0] b);
    return {sop, eop, b};
  endfunction

  task automatic applyInputs(input logic v0, input logic [8:0] d0, input logic v1, input logic [8:0] d1);
    ifA.S0_Valid = v0; ifA.S0_Byte = d0[7:0]; ifA.S0_Last = d0[8];
    ifA.S1_Valid = v1; ifA.S1_Byte = d1[7:0]; ifA.S1_Last = d1[8];
    ifB.S0_Valid = v0; ifB.S0_Byte = d0[7:0]; ifB.S0_Last = d0[8];
    ifB.S1_Valid = v1; ifB.S1_Byte = d1[7:0]; ifB.S1_Last = d1[8];
  endtask

  task automatic clearAll();
    q0.delete(); q1.delete(); outQ.delete(); expQ.delete();
    sopTick.delete(); eopTick.delete(); grantLog.delete();
    i0 = 0; i1 = 0; stallIdx1 = -1; stallLeft1 = 0;
    urCnt = 0; trCnt = 0; validTick = -1; busyFall = -1; accTick = -1;
    prevBusy = 0; lastBusy = 0; prevGrant = 2'b00; sGr = 2'b00;
  endtask

  // One clock: sample the selected DUT at the falling edge, then present this cycle's source bytes.
  task automatic tick();
    logic ev, bz, ur, tr, v0, v1, r0, r1;
    logic [9:0] eb;
    logic [8:0] d0, d1;
    @(negedge Clk);
    cyc++;
    ev  = sel ? ifB.Eth_Byte_Valid : ifA.Eth_Byte_Valid;
    eb  = sel ? ifB.Eth_Byte : ifA.Eth_Byte;
    bz  = sel ? bzB : bzA;
    ur  = sel ? urB : urA;
    tr  = sel ? trB : trA;
    sGr = sel ? grB : grA;
    if (ev) begin
      outQ.push_back(eb);
      if (eb[9]) sopTick.push_back(cyc);
      if (eb[8]) eopTick.push_back(cyc);
    end
    if (ur) urCnt++;
    if (tr) trCnt++;
    if (sGr != 2'b00 && sGr != prevGrant) grantLog.push_back(sGr);
    prevGrant = sGr;
    if (!bz && prevBusy) busyFall = cyc;
    prevBusy = bz;
    lastBusy = bz;

    v0 = (i0 < q0.size());
    v1 = (i1 < q1.size());
    if (v1 && i1 == stallIdx1 && stallLeft1 > 0) begin
      v1 = 1'b0;
      stallLeft1--;
    end
    d0 = v0 ? q0[i0] : 9'h000;
    d1 = v1 ? q1[i1] : 9'h000;
    applyInputs(v0, d0, v1, d1);
    r0 = sel ? ifB.S0_Ready : ifA.S0_Ready;
    r1 = sel ? ifB.S1_Ready : ifA.S1_Ready;
    if (v0 && r0) begin i0++; accTick = cyc; end
    if (v1 && r1) begin i1++; accTick = cyc; end
    if ((v0 || v1) && validTick < 0) validTick = cyc;
  endtask

  task automatic resetDut();
    Rst_n = 1'b0;
    applyInputs(1'b0, 9'h000, 1'b0, 9'h000);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    clearAll();
  endtask

  task automatic runUntilIdle(input int maxT, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(i0 >= q0.size() && i1 >= q1.size() && !lastBusy) && n < maxT);
    check({tag, "_completed"}, 32'(n < maxT), 32'd1);
  endtask

  task automatic checkStream(input string tag);
    check({tag, "_count"}, 32'(outQ.size()), 32'(expQ.size()));
    for (int k = 0; k < expQ.size(); k++)
      check({tag, "_byte"}, (k < outQ.size()) ? {22'd0, outQ[k]} : {32{1'bx}}, {22'd0, expQ[k]});
  endtask

  initial begin
    cyc = 0;
    sel = 1'b0;
    clearAll();

    // Reset values
    resetDut();
    check("rst_grant", grA, 2'b00);
    check("rst_busy", bzA, 1'b0);
    check("rst_vld", ifA.Eth_Byte_Valid, 1'b0);
    check("rst_byte", ifA.Eth_Byte, 10'h000);
    check("rst_rdy", {ifA.S0_Ready, ifA.S1_Ready}, 2'b00);
    check("rst_err", {urA, trA}, 2'b00);

    // 1: four-byte frame from S0
    resetDut();
    q0 = '{9'h011, 9'h022, 9'h033, 9'h144};
    runUntilIdle(800, "t1");
    expQ = '{10'h211, 10'h022, 10'h033, 10'h144};
    checkStream("t1");
    check("t1_latency", sopTick.size() > 0 ? sopTick[0] - validTick : -1, 2);
    check("t1_eop_tick", eopTick.size() > 0 ? eopTick[0] - sopTick[0] : -1, 3);
    check("t1_gap", busyFall - eopTick[0] - 1, 332);
    check("t1_grant", grantLog[0], 2'b01);

    // 2: both sources hold 60-byte frames; S0 has two queued
    resetDut();
    for (int k = 0; k < 60; k++) q0.push_back({k == 59, 8'(k)});
    for (int k = 0; k < 60; k++) q0.push_back({k == 59, 8'(100 + k)});
    for (int k = 0; k < 60; k++) q1.push_back({k == 59, 8'(8'h80 + k)});
    runUntilIdle(3000, "t2");
    for (int k = 0; k < 60; k++) expQ.push_back(mk(k == 0, k == 59, 8'(k)));
    for (int k = 0; k < 60; k++) expQ.push_back(mk(k == 0, k == 59, 8'(8'h80 + k)));
    for (int k = 0; k < 60; k++) expQ.push_back(mk(k == 0, k == 59, 8'(100 + k)));
    checkStream("t2");
    check("t2_ngrants", grantLog.size(), 3);
    check("t2_grant_order", {grantLog[0], grantLog[1], grantLog[2]}, 6'b01_10_01);
    check("t2_gap0", sopTick[1] - eopTick[0], 335);
    check("t2_gap1", sopTick[2] - eopTick[1], 335);
    check("t2_errs", urCnt + trCnt, 0);

    // 3: S1 stalls after 3 bytes of a 10-byte frame
    resetDut();
    for (int k = 0; k < 10; k++) q1.push_back({k == 9, 8'(8'hA0 + k)});
    stallIdx1 = 3;
    stallLeft1 = 3;
    runUntilIdle(1000, "t3");
    expQ = '{10'h2A0, 10'h0A1, 10'h0A2, 10'h100};
    checkStream("t3");
    check("t3_underrun", urCnt, 1);
    check("t3_trunc", trCnt, 0);
    check("t3_grant", grantLog[0], 2'b10);
    check("t3_gap", busyFall - accTick - 2, 332);

    // 4: truncation on the pMAX_PAYLOAD=8 instance
    resetDut();
    sel = 1'b1;
    for (int k = 0; k < 12; k++) q0.push_back({k == 11, 8'(k + 1)});
    runUntilIdle(1000, "t4");
    expQ = '{10'h201, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h108};
    checkStream("t4");
    check("t4_trunc", trCnt, 1);
    check("t4_underrun", urCnt, 0);
    check("t4_gap", busyFall - accTick - 2, 328);
    sel = 1'b0;

    // 5: single-byte frame
    resetDut();
    q0 = '{9'h1AB};
    runUntilIdle(800, "t5");
    expQ = '{10'h3AB};
    checkStream("t5");
    check("t5_gap", busyFall - accTick - 2, 335);

    // 6: reset during byte 5, then a fresh S1 request
    resetDut();
    for (int k = 0; k < 10; k++) q0.push_back({k == 9, 8'(8'h50 + k)});
    for (int n = 0; n < 50 && outQ.size() < 4; n++) tick();
    check("t6_reached_byte5", outQ.size(), 4);
    #2 Rst_n = 1'b0;
    #1;
    check("t6_async_vld", ifA.Eth_Byte_Valid, 1'b0);
    check("t6_async_byte", ifA.Eth_Byte, 10'h000);
    check("t6_async_grant", grA, 2'b00);
    check("t6_async_busy", bzA, 1'b0);
    check("t6_async_rdy", ifA.S0_Ready, 1'b0);
    applyInputs(1'b0, 9'h000, 1'b0, 9'h000);
    @(negedge Clk);
    Rst_n = 1'b1;
    clearAll();
    q1 = '{9'h15A};
    tick();
    tick();
    check("t6_grant_1cyc", sGr, 2'b10);
    runUntilIdle(800, "t6");
    expQ = '{10'h35A};
    checkStream("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
